t_test: RTL and testbench
=========================

# t_test

Registered WIDTH-bit binary adder with carry-in, producing sum, carry-out and status flags one clock after the operands are applied. It is the arithmetic core of the counter design. An optional accumulate mode feeds the registered sum back as the B operand, turning the block into a programmable-step counter.

## Interface
- WIDTH, 4, operand/sum width in bits; must be a multiple of 4.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B; ignored while accumulating.
- Cin  input  1  carry-in.
- acc  input  1  accumulate select; present only when T_TEST_ACC_EN is defined.
- S  output  WIDTH  registered sum.
- Cout  output  1  registered unsigned carry-out.
- V  output  1  registered signed overflow.
- Z  output  1  registered zero flag, S == 0.

## Operation
- Combinational result {c, s} = A + Bsel + Cin, computed at full WIDTH+1 precision.
- Bsel = B, except Bsel = S (current register value) when acc = 1 and T_TEST_ACC_EN is defined.
- Every clock with rst = 0: S <= s; Cout <= c; V <= (A[MSB] == Bsel[MSB]) && (s[MSB] != A[MSB]); Z <= (s == 0).
- No enable and no hold: registers load every cycle.
- Result wraps modulo 2^WIDTH. Cout marks unsigned wrap; V marks signed wrap. The two flags are independent.
- Max case: all-ones + all-ones + 1 gives S = all-ones and Cout = 1.
- Inputs X/Z are undefined; no checking is required.

## Timing
- Latency: exactly 1 cycle, from inputs sampled at edge N to outputs valid after edge N.
- Throughput: one result per cycle.
- Reset values: S = 0, Cout = 0, V = 0, Z = 1.
- rst has priority over all inputs, including acc.
- Reset asserted mid-accumulation clears S. Accumulation resumes from 0 on the first cycle after rst deasserts.
- The accumulate feedback path uses the pre-edge value of S; no combinational loop exists.

## Configuration
- T_TEST_ACC_EN defined: the acc port exists. With acc = 1, S <= S + A + Cin each cycle, so the block counts by step A and carry-in.
- T_TEST_ACC_EN undefined: no acc port; Bsel is always B. The block is a pure registered adder.
- Flag and reset behaviour are identical in both builds.

## Structure
- Package t_test_pkg holds:
  - default width constant T_TEST_WIDTH = 4;
  - a packed flags struct {cout, v, z};
  - the function computing signed overflow.
- Sub-module cla4: a combinational 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, group generate, group propagate.
- The top instantiates WIDTH/4 cla4 slices. A second-level lookahead unit across the group generate/propagate signals produces the slice carries.
- Ripple chaining of slices is not used.

## Test plan
- Hold A = 0, B = 0, Cin = 0 from time 0 for 100 ns -> after the first edge, S = 0, Cout = 0, V = 0, Z = 1.
- A = 3, B = 4, Cin = 0 -> next cycle S = 7, Cout = 0, V = 0, Z = 0. Then A = 0, B = 0, Cin = 1 -> S = 1.
- A = 15, B = 1, Cin = 0 -> S = 0, Cout = 1, Z = 1, V = 0. Then A = 15, B = 15, Cin = 1 -> S = 15, Cout = 1.
- A = 7, B = 1, Cin = 0 -> S = 8, V = 1, Cout = 0. Then A = 8, B = 8 -> S = 0, V = 1, Cout = 1, Z = 1.
- Drive a random operand stream, then assert rst for one cycle mid-stream -> S = 0, Z = 1, Cout = 0, V = 0 on that edge. Following results match A + B + Cin with 1-cycle latency.
- With T_TEST_ACC_EN: rst, then acc = 1, A = 1, Cin = 0 for 17 cycles -> S steps 1, 2, …, 15, 0, 1. Cout = 1 only on the 15 -> 0 step.

Source files
------------

// File: rtl/t_test_pkg.sv
// Shared types and helpers for the t_test registered adder.
// Holds the default width, the packed status-flag struct and the signed-overflow rule.
package t_test_pkg;

    localparam int T_TEST_WIDTH = 4;

    typedef struct packed {
        logic cout;
        logic v;
        logic z;
    } t_flags;

    // Signed wrap: both operands share a sign that the sum does not.
    function automatic logic f_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/t_test_if.sv
// Operand/result bundle for t_test; acc exists only when T_TEST_ACC_EN is defined.
// The master drives operands, the slave (the adder) drives the registered results.
interface t_test_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef T_TEST_ACC_EN
    logic             acc;
`endif
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic             Z;

    modport master (
        output A, B, Cin,
`ifdef T_TEST_ACC_EN
        output acc,
`endif
        input  S, Cout, V, Z
    );

    modport slave (
        input  A, B, Cin,
`ifdef T_TEST_ACC_EN
        input  acc,
`endif
        output S, Cout, V, Z
    );
endinterface

// File: rtl/t_test_cla4.sv
// Combinational 4-bit carry-lookahead slice exporting group generate/propagate
// so a second-level unit can form the inter-slice carries.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       gg,
    output logic       gp
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign gp = &w_p;

    assign s  = w_p ^ w_c;
    assign co = gg | (gp & ci);
endmodule

// File: rtl/t_test.sv
// Registered WIDTH-bit adder with carry-in, carry-out, signed overflow and zero flags.
// Define T_TEST_ACC_EN to add the acc input, which feeds S back as the B operand.
module t_test
    import t_test_pkg::*;
#(
    parameter int WIDTH = T_TEST_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    t_test_if.slave       bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] r_s;
    t_flags           r_flags;

    logic [WIDTH-1:0] w_bsel;
    logic [WIDTH-1:0] w_sum;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_co;
    logic [NG:0]      w_c;
    logic             w_term;
    logic             w_prod;

`ifdef T_TEST_ACC_EN
    // Feedback uses the pre-edge register value, so there is no combinational loop.
    assign w_bsel = bus.acc ? r_s : bus.B;
`else
    assign w_bsel = bus.B;
`endif

    for (genvar k = 0; k < NG; k++) begin : g_slice
        cla4 u_cla4 (
            .a  (bus.A[4*k +: 4]),
            .b  (w_bsel[4*k +: 4]),
            .ci (w_c[k]),
            .s  (w_sum[4*k +: 4]),
            .co (w_co[k]),
            .gg (w_gg[k]),
            .gp (w_gp[k])
        );
    end

    // Second-level lookahead: each slice carry is a flat sum of products of
    // group generate/propagate terms, never a slice-to-slice ripple.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_c    = '0;
        w_term = 1'b0;
        w_prod = 1'b0;
        w_c[0] = bus.Cin;
        for (int k = 0; k < NG; k++) begin
            w_term = bus.Cin;
            for (int j = 0; j <= k; j++) w_term = w_term & w_gp[j];
            for (int j = 0; j <= k; j++) begin
                w_prod = w_gg[j];
                for (int m = j + 1; m <= k; m++) w_prod = w_prod & w_gp[m];
                w_term = w_term | w_prod;
            end
            w_c[k+1] = w_term;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_s     <= '0;
            r_flags <= '{cout: 1'b0, v: 1'b0, z: 1'b1};
        end else begin
            r_s          <= w_sum;
            r_flags.cout <= w_c[NG];
            r_flags.v    <= f_overflow(bus.A[WIDTH-1], w_bsel[WIDTH-1], w_sum[WIDTH-1]);
            r_flags.z    <= (w_sum == '0);
        end
    end

    // Slice carry-outs duplicate the lookahead carries; only the top one is cross-checkable.
    logic w_unused;
    assign w_unused = ^w_co;

    assign bus.S    = r_s;
    assign bus.Cout = r_flags.cout;
    assign bus.V    = r_flags.v;
    assign bus.Z    = r_flags.z;
endmodule

// File: tb/tb_t_test.sv
// Scoreboard bench for t_test: stimulus pushes expected results computed by an
// integer-arithmetic model; a monitor pops and compares one cycle later.
module tb_t_test;
    import t_test_pkg::*;

    localparam int W    = T_TEST_WIDTH;
    localparam int MOD  = 1 << W;
    localparam int HALF = MOD / 2;

    typedef struct {
        int    s;
        int    cout;
        int    v;
        int    z;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    t_test_if #(.WIDTH(W)) bus ();

    t_test #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_s   = 0;
    bit   done  = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, want);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Apply one set of inputs for the next rising edge and record the expected result.
    task automatic drive(input int a, input int b, input int cin, input int acc_i,
                         input bit r, input string tag);
        exp_t e;
        int   bsel, sum, ssum;
        bus.A   = W'(a);
        bus.B   = W'(b);
        bus.Cin = cin[0];
        rst     = r;
`ifdef T_TEST_ACC_EN
        bus.acc = acc_i[0];
        bsel    = (acc_i != 0) ? m_s : b;
`else
        bsel    = b;
        if (acc_i != 0) bsel = b;
`endif
        e.tag = tag;
        if (r) begin
            e.s = 0; e.cout = 0; e.v = 0; e.z = 1;
        end else begin
            sum    = a + bsel + cin;
            e.s    = sum % MOD;
            e.cout = (sum >= MOD) ? 1 : 0;
            ssum   = to_signed(a) + to_signed(bsel) + cin;
            e.v    = (ssum >= HALF || ssum < -HALF) ? 1 : 0;
            e.z    = (e.s == 0) ? 1 : 0;
        end
        m_s = e.s;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are registered every cycle, so one expectation retires per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, ".S"},    int'(bus.S),    e.s);
                check({e.tag, ".Cout"}, int'(bus.Cout), e.cout);
                check({e.tag, ".V"},    int'(bus.V),    e.v);
                check({e.tag, ".Z"},    int'(bus.Z),    e.z);
            end
        end
    end

    initial begin
        int budget;
        drive(0, 0, 0, 0, 1'b1, "reset");
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1'b0, "zero_hold");

        drive(3, 4, 0, 0, 1'b0, "3+4");
        drive(0, 0, 1, 0, 1'b0, "cin_only");
        drive(15, 1, 0, 0, 1'b0, "unsigned_wrap");
        drive(15, 15, 1, 0, 1'b0, "max_case");
        drive(7, 1, 0, 0, 1'b0, "signed_ovf_pos");
        drive(8, 8, 0, 0, 1'b0, "signed_ovf_neg");

        for (int i = 0; i < 40; i++)
            drive(int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)),
                  int'($urandom_range(1)), 0, 1'b0, "rand_a");
        drive(int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)), 1, 0, 1'b1, "mid_reset");
        for (int i = 0; i < 40; i++)
            drive(int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)),
                  int'($urandom_range(1)), 0, 1'b0, "rand_b");

`ifdef T_TEST_ACC_EN
        drive(0, 0, 0, 0, 1'b1, "acc_reset");
        for (int i = 0; i < 17; i++)
            drive(1, int'($urandom_range(MOD-1)), 0, 1, 1'b0, "acc_step");
        for (int i = 0; i < 30; i++)
            drive(int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)),
                  int'($urandom_range(1)), int'($urandom_range(1)),
                  (i == 15) ? 1'b1 : 1'b0, "acc_rand");
`endif

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", q.size());
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
